// File: rtl/cla_pkg.sv
// cla_pkg: shared constants and helpers for the pipelined carry-lookahead adder.
//   OP_ADD / OP_SUB : encodings of the op_sub input.
//   nblk()          : number of lookahead slices, which is also the number of pipeline stages.
//   width_ok()      : legality of a WIDTH/BLOCK pairing. The top level calls it at elaboration.
// Optional feature macro used by this slice: CLA_OVF_EN (signed-overflow output).
package cla_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int nblk(input int width, input int block);
        return width / block;
    endfunction

    function automatic bit width_ok(input int width, input int block);
        return (block > 0) && (width >= block) && ((width % block) == 0);
    endfunction

endpackage

// File: rtl/cla_block.sv
// cla_block: combinational BLOCK-wide carry-lookahead slice.
//   a, b   in  BLOCK  operand bits (b already conditioned for subtract)
//   cin    in  1      slice carry-in
//   sum    out BLOCK  slice sum
//   cout   out 1      slice carry-out
// Optional feature macro in this design: CLA_OVF_EN (not used by this slice).
module cla_block
    import cla_pkg::*;
#(
    parameter int BLOCK = 8
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin,
    output logic [BLOCK-1:0] sum,
    output logic             cout
);

    logic [BLOCK-1:0] p_s;
    logic [BLOCK-1:0] g_s;
    logic [BLOCK:0]   c_s;
    logic             acc_s;
    logic             term_s;

    assign p_s = a ^ b;
    assign g_s = a & b;

    // Flattened lookahead: c[i] = P[i-1:0]&cin | OR_j (g[j] & P[i-1:j+1]), with no ripple between bits
    always_comb begin
        c_s    = '0;
        acc_s  = 1'b0;
        term_s = 1'b0;
        c_s[0] = cin;
        for (int i = 1; i <= BLOCK; i++) begin
            term_s = cin;
            for (int m = 0; m < i; m++) begin
                term_s = term_s & p_s[m];
            end
            acc_s = term_s;
            for (int j = 0; j < i; j++) begin
                term_s = g_s[j];
                for (int m = j + 1; m < i; m++) begin
                    term_s = term_s & p_s[m];
                end
                acc_s = acc_s | term_s;
            end
            c_s[i] = acc_s;
        end
    end

    assign sum  = p_s ^ c_s[BLOCK-1:0];
    assign cout = c_s[BLOCK];

endmodule

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: pipelined WIDTH-bit carry-lookahead adder/subtractor with a valid/ready handshake.
// Stage k resolves lookahead slice k. The whole pipe advances together when the output slot is
// free or being drained.
//   clk, rst_n           clock and asynchronous active-low reset
//   in_valid / in_ready  operand handshake (in_ready = out_ready | ~out_valid)
//   a, b, cin, op_sub    operands, add carry-in, and mode (1 = a - b, cin ignored)
//   out_valid/out_ready  result handshake. Outputs hold while stalled.
//   sum, cout            result modulo 2^WIDTH and carry-out (in subtract, 1 = no borrow)
//   ovf                  signed overflow. This port exists only when CLA_OVF_EN is defined.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CLA_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NBLK = nblk(WIDTH, BLOCK);

    if (!width_ok(WIDTH, BLOCK)) begin : g_bad_cfg
        $error("cla_pipe_adder: WIDTH must be a positive multiple of BLOCK");
    end

    logic             adv_s;
    logic [WIDTH-1:0] b_eff_s;
    logic             c0_s;

    assign adv_s    = out_ready | ~out_valid;
    assign in_ready = adv_s;

    // Operand conditioning: subtract is a + ~b + 1, and the external carry is ignored
    always_comb begin
        if (op_sub == OP_SUB) begin
            b_eff_s = ~b;
            c0_s    = 1'b1;
        end else begin
            b_eff_s = b;
            c0_s    = cin;
        end
    end

    for (genvar k = 0; k < NBLK; k++) begin : g_stage
        // UW: operand bits not yet consumed on entry to this stage. SW: result bits known after it.
        localparam int UW = WIDTH - BLOCK * k;
        localparam int SW = BLOCK * (k + 1);

        logic [UW-1:0]    ua_s;
        logic [UW-1:0]    ub_s;
        logic             ci_s;
        logic             vin_s;
        logic [BLOCK-1:0] ssum_s;
        logic             sco_s;
        logic [SW-1:0]    sum_nxt_s;
        logic             valid_r;
        logic [SW-1:0]    sum_r;
        logic             cout_r;

        if (k == 0) begin : g_head
            assign ua_s      = a;
            assign ub_s      = b_eff_s;
            assign ci_s      = c0_s;
            assign vin_s     = in_valid;
            assign sum_nxt_s = ssum_s;
        end else begin : g_body
            assign ua_s      = g_stage[k-1].g_rem.a_rem_r;
            assign ub_s      = g_stage[k-1].g_rem.b_rem_r;
            assign ci_s      = g_stage[k-1].cout_r;
            assign vin_s     = g_stage[k-1].valid_r;
            assign sum_nxt_s = {ssum_s, g_stage[k-1].sum_r};
        end

        cla_block #(
            .BLOCK (BLOCK)
        ) u_blk (
            .a    (ua_s[BLOCK-1:0]),
            .b    (ub_s[BLOCK-1:0]),
            .cin  (ci_s),
            .sum  (ssum_s),
            .cout (sco_s)
        );

        // Stage register: a bubble (vin_s = 0) moves through like data. Nothing moves while stalled.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_r <= 1'b0;
                sum_r   <= '0;
                cout_r  <= 1'b0;
            end else if (adv_s) begin
                valid_r <= vin_s;
                sum_r   <= sum_nxt_s;
                cout_r  <= sco_s;
            end
        end

        if (k < NBLK - 1) begin : g_rem
            logic [UW-BLOCK-1:0] a_rem_r;
            logic [UW-BLOCK-1:0] b_rem_r;

            // Carry the unconsumed operand bits forward alongside the partial result
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_rem_r <= '0;
                    b_rem_r <= '0;
                end else if (adv_s) begin
                    a_rem_r <= ua_s[UW-1:BLOCK];
                    b_rem_r <= ub_s[UW-1:BLOCK];
                end
            end
        end

`ifdef CLA_OVF_EN
        if (k == NBLK - 1) begin : g_tail
            logic ovf_r;

            // Signed overflow from the operand MSBs (b after inversion) and the result MSB
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_r <= 1'b0;
                end else if (adv_s) begin
                    ovf_r <= (ua_s[BLOCK-1] == ub_s[BLOCK-1]) &
                             (ssum_s[BLOCK-1] != ua_s[BLOCK-1]);
                end
            end
        end
`endif
    end

    assign out_valid = g_stage[NBLK-1].valid_r;
    assign sum       = g_stage[NBLK-1].sum_r;
    assign cout      = g_stage[NBLK-1].cout_r;
`ifdef CLA_OVF_EN
    assign ovf       = g_stage[NBLK-1].g_tail.ovf_r;
`endif

endmodule
